// File: rtl/vote_ballot_collector_if.sv
// Ballot collector bus: round control and per-voter casts in; the final ballot and
// round status out.
interface vote_ballot_collector_if #(
    parameter int N_VOTERS = 4
);
    logic                start;
    logic [N_VOTERS-1:0] cast_en;
    logic [N_VOTERS-1:0] cast_val;
    logic [N_VOTERS-1:0] ballot;
    logic                ballot_valid;
    logic [N_VOTERS-1:0] voted_mask;
    logic                busy;
    logic                timed_out;
    logic                dup_err;

    modport master (
        output start, cast_en, cast_val,
        input  ballot, ballot_valid, voted_mask, busy, timed_out, dup_err
    );

    modport slave (
        input  start, cast_en, cast_val,
        output ballot, ballot_valid, voted_mask, busy, timed_out, dup_err
    );
endinterface

// File: rtl/vote_ballot_collector.sv
// Opens a voting round, takes one ballot per voter and closes on all-voted or timeout,
// then strobes the final ballot vector to the downstream vote circuit.

// One voter's slot. The first cast of a round is final; later casts only raise dup.
module vote_ballot_slot (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic collect,
    input  logic cast_en,
    input  logic cast_val,
    output logic ballot_bit,
    output logic voted,
    output logic voted_nxt,
    output logic dup
);
    logic accept;

    assign accept    = collect & cast_en & ~voted;
    assign voted_nxt = voted | accept;
    assign dup       = collect & cast_en & voted;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ballot_bit <= 1'b0;
            voted      <= 1'b0;
        end else if (accept) begin
            ballot_bit <= cast_val;
            voted      <= 1'b1;
        end
    end
endmodule

module vote_ballot_collector #(
    parameter int N_VOTERS       = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    vote_ballot_collector_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    timer;
    logic                ballot_valid, busy, timed_out, dup_err;
    logic [N_VOTERS-1:0] ballot_q, voted_q, voted_nxt, dup_hit;
    logic                clr, collect;

    assign clr     = (state == IDLE) && bus.start;
    assign collect = (state == COLLECT);

    vote_ballot_slot u_slot [N_VOTERS-1:0] (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .collect    (collect),
        .cast_en    (bus.cast_en),
        .cast_val   (bus.cast_val),
        .ballot_bit (ballot_q),
        .voted      (voted_q),
        .voted_nxt  (voted_nxt),
        .dup        (dup_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
            timed_out    <= 1'b0;
            dup_err      <= 1'b0;
        end else begin
            ballot_valid <= 1'b0;
            dup_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        timer     <= '0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    timer   <= timer + CNT_W'(1);
                    dup_err <= |dup_hit;
                    // Close on the mask including this cycle's casts; all-voted beats timeout.
                    if (&voted_nxt) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        ballot_valid <= 1'b1;
                        timed_out    <= 1'b0;
                    end else if (timer == TMAX) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        ballot_valid <= 1'b1;
                        timed_out    <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ballot       = ballot_q;
    assign bus.voted_mask   = voted_q;
    assign bus.ballot_valid = ballot_valid;
    assign bus.busy         = busy;
    assign bus.timed_out    = timed_out;
    assign bus.dup_err      = dup_err;
endmodule

// File: tb/tb_vote_ballot_collector.sv
// Randomized and directed rounds against a first-cast-wins round model.
module tb_vote_ballot_collector;
    localparam int N    = 4;
    localparam int T    = 8;
    localparam int CW   = 3;
    localparam int MAXO = T + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vote_ballot_collector_if #(.N_VOTERS(N)) bus ();

    vote_ballot_collector #(.N_VOTERS(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [N-1:0] en_at  [MAXO];
    logic [N-1:0] val_at [MAXO];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int o = 0; o < MAXO; o++) begin
            en_at[o]  = '0;
            val_at[o] = '0;
        end
    endtask

    // Offsets count COLLECT cycles from 0; each voter's earliest cast is the one that counts.
    task automatic run_round(input string tag);
        int first [N];
        int c_close;
        logic all_in, dup, eto;
        logic [N-1:0] eb, em;
        for (int i = 0; i < N; i++) begin
            first[i] = MAXO;
            for (int o = MAXO - 1; o >= 0; o--)
                if (en_at[o][i]) first[i] = o;
        end
        all_in  = 1'b1;
        c_close = 0;
        for (int i = 0; i < N; i++) begin
            if (first[i] > T - 1) all_in = 1'b0;
            else if (first[i] > c_close) c_close = first[i];
        end
        if (!all_in) c_close = T - 1;
        eto = !all_in;
        eb = '0;
        em = '0;
        for (int i = 0; i < N; i++)
            if (first[i] <= c_close) begin
                em[i] = 1'b1;
                eb[i] = val_at[first[i]][i];
            end

        bus.start    = 1'b1;
        bus.cast_en  = N'($urandom);
        bus.cast_val = N'($urandom);
        tick();
        chk({tag, "_open_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_open_mask"}, 32'(bus.voted_mask), 32'd0);
        chk({tag, "_open_to"}, 32'(bus.timed_out), 32'd0);

        for (int o = 0; o <= c_close + 2; o++) begin
            bus.start    = (o <= c_close + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cast_en  = (o <= c_close) ? en_at[o] : N'($urandom);
            bus.cast_val = (o <= c_close) ? val_at[o] : N'($urandom);
            tick();
            dup = 1'b0;
            if (o <= c_close)
                for (int i = 0; i < N; i++)
                    if (en_at[o][i] && first[i] < o) dup = 1'b1;
            chk({tag, "_busy"}, 32'(bus.busy), 32'(o < c_close));
            chk({tag, "_valid"}, 32'(bus.ballot_valid), 32'(o == c_close));
            chk({tag, "_dup"}, 32'(bus.dup_err), 32'(dup));
            if (o == c_close) begin
                chk({tag, "_ballot"}, 32'(bus.ballot), 32'(eb));
                chk({tag, "_mask"}, 32'(bus.voted_mask), 32'(em));
                chk({tag, "_to"}, 32'(bus.timed_out), 32'(eto));
            end
        end
        bus.start   = 1'b0;
        bus.cast_en = '0;
        tick();
        chk({tag, "_hold_ballot"}, 32'(bus.ballot), 32'(eb));
        chk({tag, "_hold_mask"}, 32'(bus.voted_mask), 32'(em));
        chk({tag, "_hold_to"}, 32'(bus.timed_out), 32'(eto));
        chk({tag, "_hold_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.cast_en  = '0;
        bus.cast_val = '0;
        tick();
        tick();
        chk("rst_ballot", 32'(bus.ballot), 32'd0);
        chk("rst_valid", 32'(bus.ballot_valid), 32'd0);
        chk("rst_mask", 32'(bus.voted_mask), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_to", 32'(bus.timed_out), 32'd0);
        chk("rst_dup", 32'(bus.dup_err), 32'd0);
        rst          = 1'b0;
        bus.cast_en  = 4'hF;
        bus.cast_val = 4'hF;
        tick();
        tick();
        chk("idle_mask", 32'(bus.voted_mask), 32'd0);
        chk("idle_dup", 32'(bus.dup_err), 32'd0);
        chk("idle_ballot", 32'(bus.ballot), 32'd0);
        bus.cast_en = '0;

        clear_plan();
        en_at[0] = 4'b1111; val_at[0] = 4'b1011;
        run_round("full");
        chk("full_const", 32'(bus.ballot), 32'hB);

        clear_plan();
        en_at[1] = 4'b0001; val_at[1] = 4'b0001;
        en_at[3] = 4'b0100; val_at[3] = 4'b0100;
        en_at[4] = 4'b0001; val_at[4] = 4'b0000;
        en_at[5] = 4'b1010; val_at[5] = 4'b0000;
        run_round("stag");
        chk("stag_const", 32'(bus.ballot), 32'h5);

        clear_plan();
        en_at[2] = 4'b1000; val_at[2] = 4'b1000;
        run_round("tmo");
        chk("tmo_const", 32'(bus.ballot), 32'h8);
        chk("tmo_const_to", 32'(bus.timed_out), 32'd1);

        clear_plan();
        en_at[0]     = 4'b0111; val_at[0]     = 4'b0101;
        en_at[T - 1] = 4'b1000; val_at[T - 1] = 4'b1000;
        run_round("simul");
        chk("simul_const_to", 32'(bus.timed_out), 32'd0);

        // Reset mid-round: no strobe may escape and the next round starts clean.
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.cast_en  = 4'b0001; bus.cast_val = 4'b0001;
        tick();
        bus.cast_en  = 4'b0100; bus.cast_val = 4'b0100;
        tick();
        bus.cast_en = '0;
        rst = 1'b1;
        tick();
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_mask", 32'(bus.voted_mask), 32'd0);
        chk("mrst_ballot", 32'(bus.ballot), 32'd0);
        chk("mrst_valid", 32'(bus.ballot_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst_quiet", 32'(bus.ballot_valid), 32'd0);
        end
        clear_plan();
        en_at[1] = 4'b1111; val_at[1] = 4'b0110;
        run_round("clean");

        for (int r = 0; r < 40; r++) begin
            clear_plan();
            for (int o = 0; o < MAXO; o++) begin
                en_at[o]  = (r % 3 == 0) ? N'($urandom & $urandom & $urandom) : N'($urandom & $urandom);
                val_at[o] = N'($urandom);
            end
            run_round("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
